ic_bvsge_bvand_checker: RTL

Sequential evaluator and checker for the invertibility condition of the constraint (x & s) >=s t over W-bit signed vectors.
- Accepts one operand triple (s, t, candidate x) per transaction.
- Produces the Skolem witness and the invertibility-condition flag.
- Independently checks whether the supplied candidate x satisfies the constraint.
- Sits beside the combinational Skolem-function blocks as their bit-serial, handshaked checker for bench cross-checks and on-line validation.

---
 rtl/ic_check_pkg.sv | 21 ++
 rtl/ic_serial_sge_cmp.sv | 30 +++
 rtl/ic_bvsge_bvand_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ic_check_pkg.sv
// rtl/ic_check_pkg.sv - shared types and constants for the serial (x & s) >=s t checker
package ic_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMP_UNDEC,
    CMP_LT,
    CMP_GT
  } cmp_t;

  // Most negative W-bit value (sign bit only), returned wide; callers truncate to W.
  function automatic logic [63:0] min_const(input int w);
    return 64'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/ic_serial_sge_cmp.sv
// rtl/ic_serial_sge_cmp.sv - MSB-first bit-serial signed comparator with frozen decision
module ic_serial_sge_cmp
  import ic_check_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  input  logic is_sign,
  input  logic a_bit,
  input  logic t_bit,
  output cmp_t status
);

  cmp_t r_status;

  // The first differing bit decides; the sign bit carries inverted weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= CMP_UNDEC;
    end else if (clear) begin
      r_status <= CMP_UNDEC;
    end else if (step && (r_status == CMP_UNDEC) && (a_bit != t_bit)) begin
      r_status <= (a_bit ^ is_sign) ? CMP_GT : CMP_LT;
    end
  end

  assign status = r_status;

endmodule

// File: rtl/ic_bvsge_bvand_checker.sv
// rtl/ic_bvsge_bvand_checker.sv - handshaked serial evaluator of the IC and a candidate for (x & s) >=s t
module ic_bvsge_bvand_checker
  import ic_check_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  input  logic [W-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ic,
  output logic         out_cand_ok,
  output logic [W-1:0] out_witness,
  output logic         busy
);

  localparam logic [W-1:0]  MIN     = W'(min_const(W));
  localparam int            CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_t;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_witness;
  logic          r_res_valid;

  logic w_capture;
  logic w_step;
  logic w_is_sign;
  logic w_a_bit;
  logic w_b_bit;
  logic w_t_bit;
  cmp_t w_stat_a;
  cmp_t w_stat_b;

  assign w_capture = (r_state == ST_IDLE) && in_valid;
  assign w_step    = (r_state == ST_SHIFT);
  assign w_is_sign = (r_cnt == CNT_TOP);
  assign w_a_bit   = r_x[W-1] & r_s[W-1];
  // The witness clears the sign bit, so stream B is 0 at the MSB.
  assign w_b_bit   = r_s[W-1] & ~w_is_sign;
  assign w_t_bit   = r_t[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_s         <= '0;
      r_t         <= '0;
      r_x         <= '0;
      r_witness   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s         <= in_s;
            r_t         <= in_t;
            r_x         <= in_x;
            r_witness   <= in_s & ~MIN;
            r_cnt       <= CNT_TOP;
            r_res_valid <= 1'b0;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_s <= r_s << 1;
          r_t <= r_t << 1;
          r_x <= r_x << 1;
          if (r_cnt == '0) begin
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ic_serial_sge_cmp u_cmp_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_capture),
    .step    (w_step),
    .is_sign (w_is_sign),
    .a_bit   (w_a_bit),
    .t_bit   (w_t_bit),
    .status  (w_stat_a)
  );

  ic_serial_sge_cmp u_cmp_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_capture),
    .step    (w_step),
    .is_sign (w_is_sign),
    .a_bit   (w_b_bit),
    .t_bit   (w_t_bit),
    .status  (w_stat_b)
  );

  // Undecided after all bits means equal, which satisfies >=.
  assign out_ic      = r_res_valid && (w_stat_b != CMP_LT);
  assign out_cand_ok = r_res_valid && (w_stat_a != CMP_LT);
  assign out_witness = r_witness;
  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);

endmodule
